// File: rtl/issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_scheduler_if
// Purpose  : Issue-queue, execute-lane and retire signal bundle for issue_scheduler.
// Revision : 1.0
// ============================================================================
interface issue_scheduler_if #(
    parameter int NUM_ENTRIES  = 8,
    parameter int ENTRIES_LOG2 = 3
);
    logic                                 flush;
    logic [ENTRIES_LOG2:0]                free;
    logic [NUM_ENTRIES-1:0]               vld;
    logic [NUM_ENTRIES*ENTRIES_LOG2-1:0]  index;
    logic [NUM_ENTRIES-1:0]               ready;
    logic                                 stall;
    logic                                 complete0;
    logic                                 complete1;
    logic [ENTRIES_LOG2-1:0]              complete_slot0;
    logic [ENTRIES_LOG2-1:0]              complete_slot1;
    logic                                 pop0;
    logic                                 pop1;
    logic [ENTRIES_LOG2-1:0]              pop_key0;
    logic [ENTRIES_LOG2-1:0]              pop_key1;
    logic                                 retire0;
    logic                                 retire1;
    logic [ENTRIES_LOG2:0]                inflight;
    logic                                 err;

    modport master (
        output flush, free, vld, index, ready, stall,
        output complete0, complete1, complete_slot0, complete_slot1,
        input  pop0, pop1, pop_key0, pop_key1, retire0, retire1, inflight, err
    );

    modport slave (
        input  flush, free, vld, index, ready, stall,
        input  complete0, complete1, complete_slot0, complete_slot1,
        output pop0, pop1, pop_key0, pop_key1, retire0, retire1, inflight, err
    );
endinterface
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : issue_scheduler
// Purpose  : Dual-issue oldest-first scheduler with per-slot tracking and in-order retire.
// Revision : 1.0
// ============================================================================
module issue_scheduler #(
    parameter int NUM_ENTRIES  = 8,
    parameter int ENTRIES_LOG2 = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    issue_scheduler_if.slave sif
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUED = 2'd1,
        S_DONE   = 2'd2
    } slot_state_t;

    localparam logic [ENTRIES_LOG2:0] c_full = (ENTRIES_LOG2+1)'(NUM_ENTRIES);

    slot_state_t               r_state     [NUM_ENTRIES];
    slot_state_t               w_state_nxt [NUM_ENTRIES];
    logic [ENTRIES_LOG2:0]     r_inflight;
    logic [ENTRIES_LOG2:0]     w_inflight_nxt;
    logic                      r_err;
    logic                      w_cnt_err;
    logic                      w_cpl_err;
    logic                      w_clear;
    logic [ENTRIES_LOG2:0]     w_occ_cnt;
    logic [ENTRIES_LOG2-1:0]   w_slot      [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]    w_occ;
    logic [NUM_ENTRIES-1:0]    w_cand;
    logic                      w_pop0, w_pop1;
    logic [ENTRIES_LOG2-1:0]   w_key0, w_key1;
    logic                      w_ret0, w_ret1;
    logic                      w_same_slot, w_cpl0_ok, w_cpl1_ok;
    logic [ENTRIES_LOG2+1:0]   w_sum, w_sub, w_diff;

    assign w_clear   = reset | sif.flush;
    assign w_occ_cnt = (sif.free >= c_full) ? '0 : c_full - sif.free;

    generate
        for (genvar p = 0; p < NUM_ENTRIES; p++) begin : g_pos
            assign w_slot[p] = sif.index[p*ENTRIES_LOG2 +: ENTRIES_LOG2];
            assign w_occ[p]  = ((ENTRIES_LOG2+1)'(p) < w_occ_cnt);
            assign w_cand[p] = w_occ[p] & sif.vld[p] & sif.ready[p] &
                               (r_state[w_slot[p]] == S_IDLE) & ~sif.stall & ~w_clear;
        end
    endgenerate

    // Oldest-first pick of up to two candidates.
    always_comb begin
        w_pop0 = 1'b0;
        w_pop1 = 1'b0;
        w_key0 = '0;
        w_key1 = '0;
        for (int p = 0; p < NUM_ENTRIES; p++) begin
            if (w_cand[p]) begin
                if (!w_pop0) begin
                    w_pop0 = 1'b1;
                    w_key0 = ENTRIES_LOG2'(p);
                end else if (!w_pop1) begin
                    w_pop1 = 1'b1;
                    w_key1 = ENTRIES_LOG2'(p);
                end
            end
        end
    end

    assign w_ret0 = ~w_clear & w_occ[0] & (r_state[w_slot[0]] == S_DONE);
    assign w_ret1 = w_ret0 & w_occ[1] & (r_state[w_slot[1]] == S_DONE);

    // A same-slot collision between lanes drops both completions.
    assign w_same_slot = sif.complete0 & sif.complete1 &
                         (sif.complete_slot0 == sif.complete_slot1);
    assign w_cpl0_ok   = sif.complete0 & ~w_same_slot & (r_state[sif.complete_slot0] == S_ISSUED);
    assign w_cpl1_ok   = sif.complete1 & ~w_same_slot & (r_state[sif.complete_slot1] == S_ISSUED);
    assign w_cpl_err   = (sif.complete0 & ~w_cpl0_ok) | (sif.complete1 & ~w_cpl1_ok);

    always_comb begin
        w_sum          = {1'b0, r_inflight} + (ENTRIES_LOG2+2)'(w_pop0) + (ENTRIES_LOG2+2)'(w_pop1);
        w_sub          = (ENTRIES_LOG2+2)'(w_ret0) + (ENTRIES_LOG2+2)'(w_ret1);
        w_diff         = w_sum - w_sub;
        w_cnt_err      = 1'b0;
        w_inflight_nxt = w_diff[ENTRIES_LOG2:0];
        if (w_sum < w_sub) begin
            w_cnt_err      = 1'b1;
            w_inflight_nxt = '0;
        end else if (w_diff > {1'b0, c_full}) begin
            w_cnt_err      = 1'b1;
            w_inflight_nxt = c_full;
        end
    end

    // Pop, completion and retire touch disjoint state classes, so order is irrelevant.
    always_comb begin
        for (int s = 0; s < NUM_ENTRIES; s++) begin
            w_state_nxt[s] = r_state[s];
        end
        if (w_pop0)    w_state_nxt[w_slot[w_key0]]     = S_ISSUED;
        if (w_pop1)    w_state_nxt[w_slot[w_key1]]     = S_ISSUED;
        if (w_cpl0_ok) w_state_nxt[sif.complete_slot0] = S_DONE;
        if (w_cpl1_ok) w_state_nxt[sif.complete_slot1] = S_DONE;
        if (w_ret0)    w_state_nxt[w_slot[0]]          = S_IDLE;
        if (w_ret1)    w_state_nxt[w_slot[1]]          = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int s = 0; s < NUM_ENTRIES; s++) begin
                r_state[s] <= S_IDLE;
            end
            r_inflight <= '0;
            if (reset) begin
                r_err <= 1'b0;
            end
        end else begin
            for (int s = 0; s < NUM_ENTRIES; s++) begin
                r_state[s] <= w_state_nxt[s];
            end
            r_inflight <= w_inflight_nxt;
            r_err      <= r_err | w_cpl_err | w_cnt_err;
        end
    end

    assign sif.pop0     = w_pop0;
    assign sif.pop1     = w_pop1;
    assign sif.pop_key0 = w_key0;
    assign sif.pop_key1 = w_key1;
    assign sif.retire0  = w_ret0;
    assign sif.retire1  = w_ret1;
    assign sif.inflight = r_inflight;
    assign sif.err      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scheduler
// Purpose  : Directed scenarios plus a randomized issue-queue environment, scoreboarded
//            against a behavioural model of the scheduling rules.
// Revision : 1.0
// ============================================================================
module tb_issue_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    issue_scheduler_if #(.NUM_ENTRIES(8), .ENTRIES_LOG2(3)) sif ();
    issue_scheduler #(.NUM_ENTRIES(8), .ENTRIES_LOG2(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    typedef struct packed {
        logic       p0;
        logic [2:0] k0;
        logic       p1;
        logic [2:0] k1;
        logic       r0;
        logic       r1;
        logic [3:0] infl;
        logic       err;
    } exp_t;

    logic        rst_v, flush_v, stall_v, c0_v, c1_v;
    logic [3:0]  free_v;
    logic [7:0]  vld_v, rdy_v;
    logic [23:0] idx_v;
    logic [2:0]  cs0_v, cs1_v;

    int   st [8];          // 0 idle, 1 issued, 2 done
    int   m_infl;
    bit   m_err;
    exp_t exp_q [$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int slot_of(int p);
        return int'(idx_v[p*3 +: 3]);
    endfunction

    function automatic logic [23:0] rot_idx(int r);
        logic [23:0] v;
        for (int p = 0; p < 8; p++) v[p*3 +: 3] = 3'((p + r) % 8);
        return v;
    endfunction

    task automatic drive();
        reset              = rst_v;
        sif.flush          = flush_v;
        sif.free           = free_v;
        sif.vld            = vld_v;
        sif.index          = idx_v;
        sif.ready          = rdy_v;
        sif.stall          = stall_v;
        sif.complete0      = c0_v;
        sif.complete1      = c1_v;
        sif.complete_slot0 = cs0_v;
        sif.complete_slot1 = cs1_v;
    endtask

    task automatic set_idle();
        rst_v = 0; flush_v = 0; stall_v = 0; c0_v = 0; c1_v = 0; cs0_v = 0; cs1_v = 0;
        free_v = 4'd8; vld_v = 0; rdy_v = 0;
    endtask

    // Drives this cycle's inputs, predicts outputs from the model, then advances the model.
    task automatic apply();
        exp_t e;
        int   cand [$];
        int   ns [8];
        int   occ, nxt;
        bit   clr;
        drive();
        clr = rst_v || flush_v;
        occ = (free_v >= 4'd8) ? 0 : 8 - int'(free_v);
        for (int p = 0; p < occ; p++)
            if (vld_v[p] && rdy_v[p] && st[slot_of(p)] == 0 && !stall_v && !clr) cand.push_back(p);
        e = '0;
        if (cand.size() > 0) begin e.p0 = 1; e.k0 = 3'(cand[0]); end
        if (cand.size() > 1) begin e.p1 = 1; e.k1 = 3'(cand[1]); end
        e.r0   = !clr && occ >= 1 && st[slot_of(0)] == 2;
        e.r1   = e.r0 && occ >= 2 && st[slot_of(1)] == 2;
        e.infl = 4'(m_infl);
        e.err  = m_err;
        exp_q.push_back(e);
        cur = e;
        if (clr) begin
            foreach (st[s]) st[s] = 0;
            m_infl = 0;
            if (rst_v) m_err = 0;
        end else begin
            ns = st;
            if (c0_v && c1_v && cs0_v == cs1_v) m_err = 1;
            else begin
                if (c0_v) begin if (st[cs0_v] == 1) ns[cs0_v] = 2; else m_err = 1; end
                if (c1_v) begin if (st[cs1_v] == 1) ns[cs1_v] = 2; else m_err = 1; end
            end
            if (e.p0) ns[slot_of(cand[0])] = 1;
            if (e.p1) ns[slot_of(cand[1])] = 1;
            if (e.r0) ns[slot_of(0)] = 0;
            if (e.r1) ns[slot_of(1)] = 0;
            st  = ns;
            nxt = m_infl + int'(e.p0) + int'(e.p1) - int'(e.r0) - int'(e.r1);
            if (nxt < 0) begin m_err = 1; nxt = 0; end
            if (nxt > 8) begin m_err = 1; nxt = 8; end
            m_infl = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected record per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pop", {sif.pop0, sif.pop_key0, sif.pop1, sif.pop_key1}, {e.p0, e.k0, e.p1, e.k1});
                chk("sb_retire", {sif.retire0, sif.retire1}, {e.r0, e.r1});
                chk("sb_inflight", sif.inflight, e.infl);
                chk("sb_err", sif.err, e.err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   ent_slot [$];
        bit   ent_pop  [$];
        int   iss [$];
        int   fr  [$];
        bit   used [8];
        int   n, fill, j;

        foreach (st[s]) st[s] = 0;
        m_infl = 0; m_err = 0;
        set_idle(); rst_v = 1; idx_v = rot_idx(0);
        drive();
        tick();

        // Reset holds outputs low even with eligible entries presented.
        free_v = 0; vld_v = 8'hFF; rdy_v = 8'hFF;
        apply(); #2;
        chk("reset_pop", {sif.pop0, sif.pop1, sif.pop_key0, sif.pop_key1}, 0);
        chk("reset_state", {sif.retire0, sif.retire1, sif.inflight, sif.err}, 0);
        tick();

        // Two oldest issue, then the third.
        rst_v = 0; free_v = 5; vld_v = 8'h07; rdy_v = 8'h07;
        apply(); #2; chk("dual_pop", {sif.pop0, sif.pop_key0, sif.pop1, sif.pop_key1}, 8'b1_000_1_001); tick();
        apply(); #2; chk("single_pop", {sif.pop0, sif.pop_key0, sif.pop1, sif.pop_key1}, 8'b1_010_0_000); tick();

        // Stall blocks issue.
        free_v = 3; vld_v = 8'h1F; rdy_v = 8'h1F; stall_v = 1;
        apply(); #2; chk("stall_pop", {sif.pop0, sif.pop1}, 0); chk("stall_inflight", sif.inflight, 3); tick();
        apply(); #2; chk("stall_inflight2", sif.inflight, 3); tick();

        // In-order retire: younger done first must wait for the oldest.
        stall_v = 0; vld_v = 0; rdy_v = 0; c0_v = 1; cs0_v = 1;
        apply(); tick();
        c0_v = 0;
        apply(); #2; chk("retire_blocked", sif.retire0, 0); tick();
        c0_v = 1; cs0_v = 0;
        apply(); tick();
        c0_v = 0;
        apply(); #2; chk("retire_pair", {sif.retire0, sif.retire1}, 2'b11); tick();
        free_v = 5; idx_v = rot_idx(2);
        apply(); #2; chk("retire_inflight", sif.inflight, 1); tick();

        // Rotated index: positions drive order, slots hold state.
        rst_v = 1; apply(); tick(); rst_v = 0;
        idx_v = rot_idx(6); free_v = 4; vld_v = 8'h0F; rdy_v = 8'h0F;
        apply(); #2; chk("rot_pop_a", {sif.pop0, sif.pop_key0, sif.pop1, sif.pop_key1}, 8'b1_000_1_001); tick();
        apply(); #2; chk("rot_pop_b", {sif.pop0, sif.pop_key0, sif.pop1, sif.pop_key1}, 8'b1_010_1_011); tick();
        vld_v = 0; rdy_v = 0; c0_v = 1; cs0_v = 6; c1_v = 1; cs1_v = 7;
        apply(); tick();
        c0_v = 0; c1_v = 0;
        apply(); #2; chk("rot_retire", {sif.retire0, sif.retire1}, 2'b11); tick();

        // Bad completion sets sticky err; flush keeps it, reset clears it.
        rst_v = 1; apply(); tick(); rst_v = 0;
        c0_v = 1; cs0_v = 3; free_v = 8;
        apply(); tick();
        c0_v = 0; idx_v = rot_idx(3); free_v = 7; vld_v = 8'h01; rdy_v = 8'h01;
        apply(); #2; chk("err_set", sif.err, 1); chk("err_state_kept", {sif.pop0, sif.pop_key0}, 4'b1000); tick();
        flush_v = 1;
        apply(); #2; chk("flush_outputs", {sif.pop0, sif.retire0}, 0); tick();
        flush_v = 0; vld_v = 0;
        apply(); #2; chk("flush_inflight", sif.inflight, 0); chk("flush_err", sif.err, 1); tick();
        rst_v = 1; apply(); tick(); rst_v = 0;
        apply(); #2; chk("reset_err", sif.err, 0); tick();

        // Fill all eight, complete in pairs, retire two per cycle.
        idx_v = rot_idx(0); free_v = 0; vld_v = 8'hFF; rdy_v = 8'hFF;
        for (int k = 0; k < 4; k++) begin apply(); tick(); end
        free_v = 8;
        for (int k = 0; k < 4; k++) begin
            c0_v = 1; cs0_v = 3'(2*k); c1_v = 1; cs1_v = 3'(2*k + 1);
            apply(); #2;
            if (k == 0) chk("full_inflight", sif.inflight, 8);
            tick();
        end
        c0_v = 0; c1_v = 0; vld_v = 0; rdy_v = 0;
        for (int k = 0; k < 4; k++) begin
            free_v = 4'(2*k); idx_v = rot_idx(2*k);
            apply(); #2; chk("drain_retire", {sif.retire0, sif.retire1}, 2'b11); tick();
        end
        free_v = 8;
        apply(); #2; chk("drain_inflight", sif.inflight, 0); chk("drain_err", sif.err, 0); tick();

        // Randomized environment emulating the issue queue around the scheduler.
        rst_v = 1; apply(); tick();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            n = ent_slot.size();
            rst_v   = ($urandom_range(0, 299) == 0);
            flush_v = ($urandom_range(0, 199) == 0);
            free_v  = 4'(8 - n);
            idx_v = 0; vld_v = 0;
            foreach (used[s]) used[s] = 0;
            for (int p = 0; p < n; p++) begin
                idx_v[p*3 +: 3] = 3'(ent_slot[p]);
                used[ent_slot[p]] = 1;
                vld_v[p] = !ent_pop[p];
            end
            fill = n;
            for (int s = 0; s < 8; s++)
                if (!used[s]) begin
                    idx_v[fill*3 +: 3] = 3'(s);
                    vld_v[fill] = 1'($urandom_range(0, 1));
                    fill++;
                end
            rdy_v   = 8'($urandom);
            stall_v = ($urandom_range(0, 7) == 0);
            iss.delete();
            foreach (st[s]) if (st[s] == 1) iss.push_back(s);
            c0_v = 0; c1_v = 0; cs0_v = 3'($urandom); cs1_v = 3'($urandom);
            if (iss.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, iss.size() - 1);
                c0_v = 1; cs0_v = 3'(iss[j]); iss.delete(j);
            end
            if (iss.size() > 0 && $urandom_range(0, 1) == 1) begin
                c1_v = 1; cs1_v = 3'(iss[$urandom_range(0, iss.size() - 1)]);
            end
            apply(); tick();
            if (rst_v || flush_v) begin
                ent_slot.delete(); ent_pop.delete();
            end else begin
                if (cur.p0) ent_pop[cur.k0] = 1;
                if (cur.p1) ent_pop[cur.k1] = 1;
                if (cur.r0) begin void'(ent_slot.pop_front()); void'(ent_pop.pop_front()); end
                if (cur.r1) begin void'(ent_slot.pop_front()); void'(ent_pop.pop_front()); end
            end
            repeat ($urandom_range(0, 2)) begin
                if (ent_slot.size() < 8) begin
                    foreach (used[s]) used[s] = 0;
                    foreach (ent_slot[q]) used[ent_slot[q]] = 1;
                    fr.delete();
                    for (int s = 0; s < 8; s++) if (!used[s]) fr.push_back(s);
                    ent_slot.push_back(fr[$urandom_range(0, fr.size() - 1)]);
                    ent_pop.push_back(0);
                end
            end
        end

        set_idle(); idx_v = rot_idx(0);
        apply(); tick();
        #5;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
